// File: rtl/lut4_rv32_v2_core.sv
// Packed nibble LUT substitution: 16 x 2-bit table in rs2 indexed by rs1 nibbles.
// Combinational result plus one-cycle registered copy with valid flag.
module lut4_rv32_v2_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        hi,
    output logic [31:0] rd,
    output logic [31:0] rd_q,
    output logic        valid_q
);

    logic [1:0]  lut [16];
    logic [31:0] lo_word;
    logic [31:0] rd_d;
    logic        valid_d;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            lut[i] = rs2[2*i +: 2];
        end
    end

    // Entries land in nibble bits [1:0]; the hi shift never crosses a nibble.
    always_comb begin
        lo_word = '0;
        for (int k = 0; k < 8; k++) begin
            lo_word[4*k +: 4] = {2'b00, lut[rs1[4*k +: 4]]};
        end
    end

    assign rd = lo_word << {hi, 1'b0};

    always_comb begin
        rd_d    = valid_in ? rd : rd_q;
        valid_d = valid_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_lut4_rv32_v2_core.sv
// Directed and randomized checks for the nibble LUT unit.
module tb_lut4_rv32_v2_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        hi;
    logic [31:0] rd;
    logic [31:0] rd_q;
    logic        valid_q;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_rdq;
    logic        exp_vq;
    logic [31:0] m;

    lut4_rv32_v2_core dut (
        .clk      (clk),
        .reset    (reset),
        .valid_in (valid_in),
        .rs1      (rs1),
        .rs2      (rs2),
        .hi       (hi),
        .rd       (rd),
        .rd_q     (rd_q),
        .valid_q  (valid_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Per-nibble reference: pick entry by shifting the table down.
    function automatic logic [31:0] model(input logic [31:0] a,
                                          input logic [31:0] t,
                                          input logic h);
        logic [31:0] r;
        logic [31:0] s;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            s = t >> (2 * a[4*k +: 4]);
            r[4*k +: 4] = h ? {s[1:0], 2'b00} : {2'b00, s[1:0]};
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] t, input logic h);
        valid_in = v;
        rs1      = a;
        rs2      = t;
        hi       = h;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #2;
        chk("reset_rdq", rd_q, 32'h0);
        chk("reset_vq", {31'b0, valid_q}, 32'h0);

        @(negedge clk);
        reset = 1'b0;

        drive(1'b0, 32'h76543210, 32'hE4E4E4E4, 1'b0);
        #1 chk("e4_lo", rd, 32'h32103210);
        hi = 1'b1;
        #1 chk("e4_hi", rd, 32'hC840C840);

        drive(1'b0, 32'h00000000, 32'h00000003, 1'b0);
        #1 chk("l0_idx0", rd, 32'h33333333);
        rs1 = 32'h11111111;
        #1 chk("l0_idx1", rd, 32'h0);
        drive(1'b0, 32'hF0F0F0F0, 32'h00000003, 1'b1);
        #1 chk("l0_f0_hi", rd, 32'h0C0C0C0C);

        drive(1'b0, 32'h9A3C5E71, 32'hFFFFFFFF, 1'b0);
        #1 chk("ones_lo", rd, 32'h33333333);
        hi = 1'b1;
        #1 chk("ones_hi", rd, 32'hCCCCCCCC);
        drive(1'b0, 32'h9A3C5E71, 32'h00000000, 1'b1);
        #1 chk("zero_hi", rd, 32'h0);
        hi = 1'b0;
        #1 chk("zero_lo", rd, 32'h0);

        // Capture A, then hold with valid low.
        @(negedge clk);
        drive(1'b1, 32'h76543210, 32'hE4E4E4E4, 1'b1);
        @(posedge clk);
        #1 chk("pipe_a_rdq", rd_q, 32'hC840C840);
        chk("pipe_a_vq", {31'b0, valid_q}, 32'h1);
        @(negedge clk);
        drive(1'b0, 32'h00000000, 32'h00000003, 1'b0);
        @(posedge clk);
        #1 chk("pipe_hold_rdq", rd_q, 32'hC840C840);
        chk("pipe_hold_vq", {31'b0, valid_q}, 32'h0);

        // Mid-stream async reset.
        @(negedge clk);
        drive(1'b1, 32'h00000000, 32'h00000003, 1'b0);
        @(posedge clk);
        #1 chk("pre_rst_rdq", rd_q, 32'h33333333);
        chk("pre_rst_vq", {31'b0, valid_q}, 32'h1);
        #2 reset = 1'b1;
        #1 chk("async_rst_rdq", rd_q, 32'h0);
        chk("async_rst_vq", {31'b0, valid_q}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 32'hF0F0F0F0, 32'h00000003, 1'b1);
        @(posedge clk);
        #1 chk("post_rst_rdq", rd_q, 32'h0C0C0C0C);
        chk("post_rst_vq", {31'b0, valid_q}, 32'h1);

        exp_rdq = 32'h0C0C0C0C;
        for (int n = 0; n < 1200; n++) begin
            @(negedge clk);
            drive($urandom_range(0, 1) == 1, $urandom, $urandom,
                  $urandom_range(0, 1) == 1);
            m = model(rs1, rs2, hi);
            #1 chk("rand_rd", rd, m);
            exp_vq = valid_in;
            if (valid_in) exp_rdq = m;
            @(posedge clk);
            #1 chk("rand_rdq", rd_q, exp_rdq);
            chk("rand_vq", {31'b0, valid_q}, {31'b0, exp_vq});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
